// File: rtl/conv_pkg.sv
// conv_pkg: shared types and helpers for the convolution engine.
//   state_e  : engine FSM states
//   out_dim  : output extent for a given image side, kernel side and stride
//   clamp_u  : saturate a signed value into the unsigned range [0, 2^w-1]
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic int out_dim(input int img, input int k, input int s);
        return (img - k) / s + 1;
    endfunction

    function automatic logic [31:0] clamp_u(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        hi = (64'sd1 <<< w) - 64'sd1;
        if (v < 64'sd0) begin
            return 32'd0;
        end else if (v > hi) begin
            return 32'(hi);
        end else begin
            return 32'(v);
        end
    endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// conv_mac_lane: one multiply-accumulate lane of the convolution engine.
// The accumulator is cleared by clr_i, accumulates pixel*tap when en_i is
// high, and its value is arithmetically shifted and clamped to DATA_W bits.
//   clk_i  : clock
//   rst_ni : synchronous active-low reset
//   clr_i  : clear accumulator (has priority over en_i)
//   en_i   : accumulate this cycle
//   pix_i  : unsigned pixel
//   tap_i  : signed kernel tap
//   res_o  : clamped result of the current accumulator
module conv_mac_lane
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int SHIFT  = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic [DATA_W-1:0]        pix_i,
    input  logic signed [DATA_W-1:0] tap_i,
    output logic [DATA_W-1:0]        res_o
);

    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [2*DATA_W:0] prod;
    logic signed [ACC_W-1:0]  shifted;

    always_comb begin
        // zero-extend the pixel so it is treated as a non-negative signed value
        prod  = $signed({1'b0, pix_i}) * tap_i;
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign shifted = acc_q >>> SHIFT;
    assign res_o   = DATA_W'(clamp_u(64'(shifted), DATA_W));

endmodule

// File: rtl/conv_engine.sv
// conv_engine: multi-lane KxK convolution over an IMG_H x IMG_W 8-bit image
// held in external RAM. Each group produces LANES horizontally adjacent
// output pixels; groups are produced row-major with a ready/valid handshake.
//   i_clk, i_rst       : clock, synchronous active-low reset
//   i_start            : frame start (honoured only in IDLE)
//   i_src_base         : image base address, latched on start
//   i_stride           : stride, latched on start (0 behaves as 1)
//   i_kw_en/addr/data  : kernel tap writes, accepted only in IDLE
//   o_rd_addr          : per-lane RAM read address (1-cycle read latency)
//   i_rd_data          : per-lane pixel returned by the RAM
//   o_valid, i_ready   : output group handshake
//   o_sum, o_lane_vld  : clamped lane results and per-lane validity
//   o_out_row/col      : output coordinates of lane 0
//   o_busy, o_done     : frame in progress / end-of-frame pulse
//
// state | meaning
// IDLE  | waiting for i_start, kernel writable
// MAC   | issuing K*K tap reads, then one drain cycle for read latency
// OUT   | group result presented, waiting for i_ready
// DONE  | one-cycle end-of-frame pulse
module conv_engine
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 3,
    parameter int LANES  = 2,
    parameter int ACC_W  = 24,
    parameter int SHIFT  = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [ADDR_W-1:0]         i_src_base,
    input  logic [2:0]                i_stride,
    input  logic                      i_kw_en,
    input  logic [$clog2(K*K)-1:0]    i_kw_addr,
    input  logic [DATA_W-1:0]         i_kw_data,
    output logic [LANES*ADDR_W-1:0]   o_rd_addr,
    input  logic [LANES*DATA_W-1:0]   i_rd_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [LANES*DATA_W-1:0]   o_sum,
    output logic [LANES-1:0]          o_lane_vld,
    output logic [ADDR_W-1:0]         o_out_row,
    output logic [ADDR_W-1:0]         o_out_col,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int KK    = K * K;
    localparam int TAP_W = $clog2(KK + 1);

    state_e state_q, state_d;

    logic [TAP_W-1:0]  tap_q, tap_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [2:0]        stride_q, stride_d;
    logic [ADDR_W-1:0] out_w_q, out_w_d;
    logic [ADDR_W-1:0] out_h_q, out_h_d;

    logic signed [DATA_W-1:0] kern_q [KK];

    logic [2:0]        stride_eff;
    logic [ADDR_W-1:0] stride_w;
    logic [ADDR_W-1:0] next_col;
    logic              row_end;
    logic              last_grp;
    logic              issue;
    logic              kw_we;
    logic [TAP_W-1:0]  tap_sel;
    logic signed [DATA_W-1:0] tap_cur;

    logic [ADDR_W-1:0] lane_col [LANES];
    logic [LANES-1:0]  lane_ok;
    logic [ADDR_W-1:0] rd_addr;
    int                kr_i;
    int                kc_i;
    logic [DATA_W-1:0] lane_res [LANES];

    assign stride_eff = (i_stride == 3'd0) ? 3'd1 : i_stride;
    assign stride_w   = ADDR_W'(stride_q);
    assign next_col   = col_q + ADDR_W'(LANES);
    assign row_end    = next_col >= out_w_q;
    assign last_grp   = row_end && (row_q == out_h_q - ADDR_W'(1));
    assign issue      = (state_q == MAC) && (tap_q < TAP_W'(KK));
    assign kw_we      = (state_q == IDLE) && i_kw_en && (32'(i_kw_addr) < KK);

    // data returning in this cycle belongs to the previous tap
    assign tap_sel = (tap_q == '0) ? '0 : tap_q - TAP_W'(1);
    assign tap_cur = kern_q[tap_sel];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (i_start) state_d = MAC;
            MAC:  if (tap_q == TAP_W'(KK)) state_d = OUT;
            OUT:  if (i_ready) state_d = last_grp ? DONE : MAC;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_valid   = (state_q == OUT);
        o_busy    = (state_q == MAC) || (state_q == OUT);
        o_done    = (state_q == DONE);
        o_out_row = o_busy ? row_q : '0;
        o_out_col = o_busy ? col_q : '0;
    end

    // ---------------- frame / group counters ----------------
    always_comb begin
        tap_d    = tap_q;
        row_d    = row_q;
        col_d    = col_q;
        base_d   = base_q;
        stride_d = stride_q;
        out_w_d  = out_w_q;
        out_h_d  = out_h_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    base_d   = i_src_base;
                    stride_d = stride_eff;
                    out_w_d  = ADDR_W'(out_dim(IMG_W, K, int'(stride_eff)));
                    out_h_d  = ADDR_W'(out_dim(IMG_H, K, int'(stride_eff)));
                    row_d    = '0;
                    col_d    = '0;
                    tap_d    = '0;
                end
            end
            MAC: begin
                tap_d = (tap_q == TAP_W'(KK)) ? '0 : tap_q + TAP_W'(1);
            end
            OUT: begin
                if (i_ready) begin
                    tap_d = '0;
                    if (row_end) begin
                        col_d = '0;
                        row_d = row_q + ADDR_W'(1);
                    end else begin
                        col_d = next_col;
                    end
                end
            end
            DONE: begin
                row_d = '0;
                col_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            tap_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            base_q   <= '0;
            stride_q <= 3'd1;
            out_w_q  <= '0;
            out_h_q  <= '0;
        end else begin
            tap_q    <= tap_d;
            row_q    <= row_d;
            col_q    <= col_d;
            base_q   <= base_d;
            stride_q <= stride_d;
            out_w_q  <= out_w_d;
            out_h_q  <= out_h_d;
        end
    end

    // ---------------- kernel register file ----------------
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int k = 0; k < KK; k++) begin
                kern_q[k] <= '0;
            end
        end else if (kw_we) begin
            kern_q[i_kw_addr] <= i_kw_data;
        end
    end

    // ---------------- address generation ----------------
    // All arithmetic is done in ADDR_W bits so addresses wrap modulo 2^ADDR_W.
    always_comb begin
        kr_i      = int'(tap_q) / K;
        kc_i      = int'(tap_q) % K;
        o_rd_addr = '0;
        rd_addr   = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_col[l] = col_q + ADDR_W'(l);
            lane_ok[l]  = lane_col[l] < out_w_q;
            rd_addr = base_q
                    + (row_q * stride_w + ADDR_W'(kr_i)) * ADDR_W'(IMG_W)
                    + lane_col[l] * stride_w + ADDR_W'(kc_i);
            if (issue && lane_ok[l]) begin
                o_rd_addr[l*ADDR_W +: ADDR_W] = rd_addr;
            end
        end
    end

    // ---------------- MAC lanes ----------------
    for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
        conv_mac_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W),
            .SHIFT  (SHIFT)
        ) u_lane (
            .clk_i  (i_clk),
            .rst_ni (i_rst),
            .clr_i  ((state_q == MAC) && (tap_q == '0)),
            .en_i   ((state_q == MAC) && (tap_q != '0) && lane_ok[gl]),
            .pix_i  (i_rd_data[gl*DATA_W +: DATA_W]),
            .tap_i  (tap_cur),
            .res_o  (lane_res[gl])
        );
    end

    always_comb begin
        o_sum      = '0;
        o_lane_vld = '0;
        for (int l = 0; l < LANES; l++) begin
            o_lane_vld[l] = (state_q == OUT) && lane_ok[l];
            if (o_lane_vld[l]) begin
                o_sum[l*DATA_W +: DATA_W] = lane_res[l];
            end
        end
    end

endmodule
